pattern_sync_gen: RTL and testbench
===================================

// Module: pattern_sync_gen
// PURPOSE
// Frame/line timing source sitting directly upstream of the pattern generator.
// Issues the f_sync/sync pulse train that walks the generator through OFF->WAIT->COUNT.
// Holds shadow copies of the pattern configuration (Mode, constVal, X, Y), latched only at frame start,
// so the generator sees configuration that is stable for a whole frame.
// PARAMETERS
// LINES      23  line sync pulses per frame (excl. the frame-start pulse)
// GUARD      4   idle cycles appended after each line's pixel count
// FRAME_GAP  64  idle cycles between frames in continuous operation
// PORTS
// clk         in   1   16ns master clock
// rst_n       in   1   async active-low reset
// en          in   1   block enable; low aborts any frame
// frame_req   in   1   one-cycle request for a single frame
// continuous  in   1   1 = frames back-to-back, separated by FRAME_GAP
// cfg_mode    in   3   requested work mode (pg_pkg encoding)
// cfg_const   in   12  requested constant value
// cfg_x       in   2   requested ramp deltaX code
// cfg_y       in   2   requested ramp deltaY code
// f_sync      out  1   frame-start pulse, 1 cycle
// sync        out  1   line pulse, 1 cycle
// Mode        out  3   shadow mode, to generator
// constVal    out  12  shadow constant, to generator
// X, Y        out  2   shadow ramp codes, to generator
// busy        out  1   high from frame start until return to IDLE/GAP
// frame_done  out  1   1-cycle pulse after the last line completes
// line_idx    out  5   index of the current line, 0..LINES-1
// BEHAVIOUR
// - Reset: all outputs 0 and state IDLE; counters 0; shadow registers 0.
// - Line length L is taken from shadow Mode:
//   - REGULAR(001): L = 4096+GUARD.
//   - All other modes, including 000: L = 1290+GUARD.
// - FSM IDLE -> START -> LINE -> (LINE | GAP | IDLE):
//   - IDLE: on en & (frame_req | continuous), latch cfg_* into shadow, go to START.
//   - START: one cycle with f_sync=1, sync=1, busy=1.
//   - LINE:
//     - The first cycle of each line drives sync=1 (f_sync=0), with line_idx = line number.
//     - The first line's sync falls in the cycle after START.
//     - A 13-bit down-counter loads L-1 at sync and the line ends at 0.
//     - The next sync follows exactly L cycles after the previous one.
//   - After line LINES-1 ends: pulse frame_done for 1 cycle and drop busy.
//     - continuous=1: go to GAP.
//     - Otherwise: go to IDLE.
//   - GAP: count FRAME_GAP cycles.
//     - At the end, if en & continuous: relatch cfg_*, go to START.
//     - Otherwise: go to IDLE.
// - Shadow registers change only on the IDLE->START or GAP->START transitions; cfg_* changes mid-frame are ignored.
// - frame_req while busy or in GAP is ignored (not queued).
// - en low in any state: next cycle goes to IDLE, sync/f_sync/busy = 0, counters cleared, no frame_done.
//   - Shadow registers keep their values.
// - frame_req and en rising in the same cycle: the frame starts.
// - continuous dropped mid-frame: the current frame completes, then the FSM goes to IDLE.
// - sync and f_sync are never high outside START/LINE first cycles.
// - line_idx wraps to 0 only at the next START.
// - Async reset mid-frame: outputs go low immediately, no partial frame_done.
// STRUCTURE
// - pg_pkg holds:
//   - mode constants REGULAR..RAMP_MODE;
//   - line lengths PIX_REGULAR=4096, PIX_LINE=1290;
//   - the state enum typedef sync_state_t.
// - One sub-module: pg_down_counter (loadable 13-bit down-counter with zero flag), reused for the line counter and the gap counter.
// TESTING
// - rst_n low, then frame_req with cfg_mode=010, LINES=23:
//   - START pulse with f_sync=sync=1.
//   - 23 syncs spaced 1294 cycles apart.
//   - frame_done 1294 cycles after the last sync.
// - cfg_mode=001: sync spacing is 4100 cycles; Mode output = 001 for the whole frame.
// - Change cfg_const from 0x123 to 0x456 during line 5: constVal stays 0x123 until the next START.
// - continuous=1, FRAME_GAP=64: next f_sync arrives 64 cycles after frame_done and latches new cfg.
// - en dropped during line 10: sync stops next cycle, busy=0, no frame_done, FSM in IDLE.
// - frame_req pulsed while busy: no extra frame; a reset pulse mid-line leaves all outputs at 0.

Source files
------------

// File: rtl/pg_pkg.sv
// -----------------------------------------------------------------------------
// pg_pkg
// Shared definitions for the pattern generator timing path:
//   - work-mode encodings seen on Mode / cfg_mode
//   - active pixel counts per line for each mode family
//   - state type of the frame/line sync FSM
//   - helper computing the full line length (pixels + guard)
// -----------------------------------------------------------------------------
package pg_pkg;

    localparam logic [2:0] OFF_MODE   = 3'b000;
    localparam logic [2:0] REGULAR    = 3'b001;
    localparam logic [2:0] CONST_MODE = 3'b010;
    localparam logic [2:0] RAMP_MODE  = 3'b011;

    localparam int PIX_REGULAR = 4096;
    localparam int PIX_LINE    = 1290;

    // Width of the line/gap down-counters; must hold PIX_REGULAR + GUARD - 1.
    localparam int CNT_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_LINE,
        ST_GAP
    } sync_state_t;

    // REGULAR lines are long; every other mode, including OFF, uses the short line.
    function automatic logic [CNT_W-1:0] line_len(input logic [2:0] mode, input int guard);
        if (mode == REGULAR) begin
            return CNT_W'(PIX_REGULAR + guard);
        end
        return CNT_W'(PIX_LINE + guard);
    endfunction

endpackage

// File: rtl/pg_down_counter.sv
// -----------------------------------------------------------------------------
// pg_down_counter
// Loadable down-counter with a zero flag. Stops at zero.
// Ports:
//   clk      in  clock
//   rst_n    in  async active-low reset
//   clear    in  synchronous clear to zero (highest priority)
//   load     in  load load_val this cycle
//   load_val in  value to load
//   zero     out count is zero
// -----------------------------------------------------------------------------
module pg_down_counter #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_sync_gen.sv
// -----------------------------------------------------------------------------
// pattern_sync_gen
// Frame/line timing source for the pattern generator. Emits a frame-start
// pulse followed by LINES line pulses, and holds shadow copies of the pattern
// configuration that only change at frame start.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   en                            block enable, low aborts the frame
//   frame_req                     one-cycle single-frame request
//   continuous                    run frames back to back with FRAME_GAP idle cycles
//   cfg_mode/cfg_const/cfg_x/y    requested configuration
//   f_sync, sync                  frame-start pulse, line pulse
//   Mode, constVal, X, Y          shadow configuration to the generator
//   busy                          frame in progress
//   frame_done                    pulse after the last line completes
//   line_idx                      current line number
// -----------------------------------------------------------------------------
module pattern_sync_gen
    import pg_pkg::*;
#(
    parameter int LINES     = 23,
    parameter int GUARD     = 4,
    parameter int FRAME_GAP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_req,
    input  logic        continuous,
    input  logic [2:0]  cfg_mode,
    input  logic [11:0] cfg_const,
    input  logic [1:0]  cfg_x,
    input  logic [1:0]  cfg_y,
    output logic        f_sync,
    output logic        sync,
    output logic [2:0]  Mode,
    output logic [11:0] constVal,
    output logic [1:0]  X,
    output logic [1:0]  Y,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  line_idx
);

    localparam logic [4:0]       LAST_LINE = 5'(LINES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(FRAME_GAP - 1);

    sync_state_t state;

    logic line_load;
    logic line_zero;
    logic gap_load;
    logic gap_zero;
    logic [CNT_W-1:0] line_load_val;

    // The counter holds L-1 during a sync cycle, so reaching zero marks the
    // last cycle of the line and the next sync lands exactly L cycles later.
    assign line_load_val = line_len(Mode, GUARD) - 1'b1;

    always_comb begin
        line_load = 1'b0;
        gap_load  = 1'b0;
        if (en) begin
            case (state)
                ST_START: line_load = 1'b1;
                ST_LINE: begin
                    if (line_zero) begin
                        if (line_idx != LAST_LINE) begin
                            line_load = 1'b1;
                        end else if (continuous) begin
                            gap_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    pg_down_counter #(.WIDTH(CNT_W)) u_line_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!en),
        .load     (line_load),
        .load_val (line_load_val),
        .zero     (line_zero)
    );

    pg_down_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!en),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            f_sync     <= 1'b0;
            sync       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_idx   <= '0;
            Mode       <= '0;
            constVal   <= '0;
            X          <= '0;
            Y          <= '0;
        end else begin
            f_sync     <= 1'b0;
            sync       <= 1'b0;
            frame_done <= 1'b0;
            if (!en) begin
                // Abort: shadow configuration is deliberately kept.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                line_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_req || continuous) begin
                            Mode     <= cfg_mode;
                            constVal <= cfg_const;
                            X        <= cfg_x;
                            Y        <= cfg_y;
                            f_sync   <= 1'b1;
                            sync     <= 1'b1;
                            busy     <= 1'b1;
                            line_idx <= '0;
                            state    <= ST_START;
                        end
                    end
                    ST_START: begin
                        sync     <= 1'b1;
                        line_idx <= '0;
                        state    <= ST_LINE;
                    end
                    ST_LINE: begin
                        if (line_zero) begin
                            if (line_idx == LAST_LINE) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state      <= continuous ? ST_GAP : ST_IDLE;
                            end else begin
                                sync     <= 1'b1;
                                line_idx <= line_idx + 5'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_zero) begin
                            if (continuous) begin
                                Mode     <= cfg_mode;
                                constVal <= cfg_const;
                                X        <= cfg_x;
                                Y        <= cfg_y;
                                f_sync   <= 1'b1;
                                sync     <= 1'b1;
                                busy     <= 1'b1;
                                line_idx <= '0;
                                state    <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_sync_gen
// Self-checking bench for pattern_sync_gen. LINES is reduced to 11 so several
// complete frames fit in a short run; line lengths use the real GUARD.
// -----------------------------------------------------------------------------
module tb_pattern_sync_gen;

    localparam int LINES     = 11;
    localparam int GUARD     = 4;
    localparam int FRAME_GAP = 64;
    localparam int LEN_LINE  = 1290 + GUARD;
    localparam int LEN_REG   = 4096 + GUARD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        frame_req;
    logic        continuous;
    logic [2:0]  cfg_mode;
    logic [11:0] cfg_const;
    logic [1:0]  cfg_x;
    logic [1:0]  cfg_y;
    logic        f_sync;
    logic        sync;
    logic [2:0]  Mode;
    logic [11:0] constVal;
    logic [1:0]  X;
    logic [1:0]  Y;
    logic        busy;
    logic        frame_done;
    logic [4:0]  line_idx;

    int checks = 0;
    int errors = 0;
    int n = 0;

    pattern_sync_gen #(
        .LINES     (LINES),
        .GUARD     (GUARD),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .frame_req  (frame_req),
        .continuous (continuous),
        .cfg_mode   (cfg_mode),
        .cfg_const  (cfg_const),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .f_sync     (f_sync),
        .sync       (sync),
        .Mode       (Mode),
        .constVal   (constVal),
        .X          (X),
        .Y          (Y),
        .busy       (busy),
        .frame_done (frame_done),
        .line_idx   (line_idx)
    );

    initial forever #8 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, n, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic req, input logic cont,
                                 input logic [2:0] m, input logic [11:0] c,
                                 input logic [1:0] x, input logic [1:0] y);
        en         = e;
        frame_req  = req;
        continuous = cont;
        cfg_mode   = m;
        cfg_const  = c;
        cfg_x      = x;
        cfg_y      = y;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: tracks frame start / gap start edge numbers and derives
    // every output from the offset into the frame with plain arithmetic.
    int          m_phase = 0;   // 0 idle, 1 frame, 2 gap
    int          m_fs    = 0;
    int          m_gd    = 0;
    int          m_len   = LEN_LINE;
    int          m_idx   = 0;
    logic [2:0]  m_mode  = '0;
    logic [11:0] m_const = '0;
    logic [1:0]  m_x     = '0;
    logic [1:0]  m_y     = '0;
    logic        e_fsync, e_sync, e_busy, e_done;

    task automatic modelLatch();
        m_mode  = cfg_mode;
        m_const = cfg_const;
        m_x     = cfg_x;
        m_y     = cfg_y;
        m_len   = (cfg_mode == 3'b001) ? LEN_REG : LEN_LINE;
        m_phase = 1;
        m_fs    = n;
    endtask

    task automatic modelStep();
        int off;
        e_fsync = 1'b0;
        e_sync  = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_idx   = 0;
            m_mode  = '0;
            m_const = '0;
            m_x     = '0;
            m_y     = '0;
        end else if (!en) begin
            m_phase = 0;
            m_idx   = 0;
        end else begin
            if (m_phase == 2) begin
                if (n - m_gd == FRAME_GAP) begin
                    if (continuous) modelLatch();
                    else m_phase = 0;
                end
            end else if (m_phase == 0) begin
                if (frame_req || continuous) modelLatch();
            end else begin
                off = n - m_fs;
                if (off == 1 + LINES * m_len) begin
                    e_done = 1'b1;
                    m_idx  = LINES - 1;
                    if (continuous) begin
                        m_phase = 2;
                        m_gd    = n;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    e_busy = 1'b1;
                    e_sync = ((off - 1) % m_len) == 0;
                    m_idx  = (off - 1) / m_len;
                end
            end
            if (m_phase == 1 && m_fs == n) begin
                e_fsync = 1'b1;
                e_sync  = 1'b1;
                e_busy  = 1'b1;
                m_idx   = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #4;
            n++;
            modelStep();
            checkOutput("cycle_model",
                        {4'd0, f_sync, sync, busy, frame_done, line_idx, Mode, constVal, X, Y},
                        {4'd0, e_fsync, e_sync, e_busy, e_done, 5'(m_idx), m_mode, m_const, m_x, m_y});
        end
    end

    initial begin
        #(16 * 100000);
        $display("[TB] FAIL watchdog: run exceeded cycle budget, got cycle %0d, expected completion", n);
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0]  mode;
        logic [11:0] cval;
        logic [1:0]  x;
        logic [1:0]  y;
        int          exp_len;
        logic [2:0]  exp_mode;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int t0, got, nsync, spacing_err, last, nfs, done_at, fs_at, cnt;
        logic [11:0] const_at_done;
        logic busy_at_done;

        tbl[0] = '{mode: 3'b010, cval: 12'h123, x: 2'd1, y: 2'd2, exp_len: LEN_LINE, exp_mode: 3'b010};
        tbl[1] = '{mode: 3'b001, cval: 12'habc, x: 2'd3, y: 2'd0, exp_len: LEN_REG,  exp_mode: 3'b001};
        tbl[2] = '{mode: 3'b000, cval: 12'hfff, x: 2'd0, y: 2'd3, exp_len: LEN_LINE, exp_mode: 3'b000};
        tbl[3] = '{mode: 3'b111, cval: 12'h001, x: 2'd2, y: 2'd1, exp_len: LEN_LINE, exp_mode: 3'b111};

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 12'h000, 2'd0, 2'd0);
        rst_n = 1'b0;
        tick(); tick(); tick();
        checkOutput("reset_state", {f_sync, sync, busy, frame_done, line_idx, Mode, constVal, X, Y}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: start, first line spacing, shadow contents, abort
        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, tbl[v].mode, tbl[v].cval, tbl[v].x, tbl[v].y);
            tick();
            frame_req = 1'b0;
            checkOutput("tbl_start", {f_sync, sync, busy}, 3'b111);
            tick();
            checkOutput("tbl_line0", {f_sync, sync, line_idx}, {1'b0, 1'b1, 5'd0});
            t0  = n;
            got = -1;
            for (int k = 0; k < tbl[v].exp_len + 8 && got < 0; k++) begin
                tick();
                if (sync) got = n - t0;
            end
            checkOutput("tbl_spacing", got, tbl[v].exp_len);
            checkOutput("tbl_line1_idx", line_idx, 32'd1);
            checkOutput("tbl_shadow", {Mode, constVal, X, Y}, {tbl[v].exp_mode, tbl[v].cval, tbl[v].x, tbl[v].y});
            en = 1'b0;
            tick();
            checkOutput("tbl_abort", {f_sync, sync, busy, frame_done}, 4'd0);
            en = 1'b1;
            tick();
        end

        // Full single frame, cfg change during line 5, frame_req while busy
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 12'h123, 2'd1, 2'd1);
        tick();
        frame_req = 1'b0;
        checkOutput("full_start", {f_sync, sync, busy}, 3'b111);
        nsync = 0; spacing_err = 0; last = -1; nfs = 0; done_at = -1;
        const_at_done = '0; busy_at_done = 1'b1;
        for (int i = 0; i < LINES * LEN_LINE + 50 && done_at < 0; i++) begin
            tick();
            frame_req = 1'b0;
            if (f_sync) nfs++;
            if (sync && !f_sync) begin
                if (last >= 0 && n - last != LEN_LINE) spacing_err++;
                last = n;
                nsync++;
                if (line_idx == 5'd5) cfg_const = 12'h456;
                if (line_idx == 5'd3) frame_req = 1'b1;
            end
            if (frame_done) begin
                done_at       = n;
                const_at_done = constVal;
                busy_at_done  = busy;
            end
        end
        checkOutput("full_sync_count", nsync, LINES);
        checkOutput("full_spacing_errs", spacing_err, 32'd0);
        checkOutput("full_done_seen", done_at >= 0, 1'b1);
        checkOutput("full_done_delay", done_at - last, LEN_LINE);
        checkOutput("full_const_held", const_at_done, 12'h123);
        checkOutput("full_busy_at_done", busy_at_done, 1'b0);
        checkOutput("full_no_extra_fsync", nfs, 32'd0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (f_sync || busy || sync) cnt++;
        end
        checkOutput("req_not_queued", cnt, 32'd0);

        // Next frame picks up the new constant; then async reset mid-line
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        checkOutput("relatch_456", {f_sync, constVal}, {1'b1, 12'h456});
        for (int i = 0; i < LEN_LINE + 20; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {f_sync, sync, busy, frame_done, line_idx, Mode, constVal, X, Y}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checkOutput("after_reset_idle", {f_sync, sync, busy, frame_done}, 4'd0);

        // Continuous: gap length and relatch, then drop continuous mid-frame
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 12'h111, 2'd0, 2'd0);
        tick();
        checkOutput("cont_start", {f_sync, constVal}, {1'b1, 12'h111});
        done_at = -1;
        for (int i = 0; i < LINES * LEN_LINE + 50 && done_at < 0; i++) begin
            tick();
            if (sync && line_idx == 5'd2) begin
                cfg_const = 12'h222; cfg_mode = 3'b011; cfg_x = 2'd2; cfg_y = 2'd3;
            end
            if (frame_done) done_at = n;
        end
        checkOutput("cont_done_seen", done_at >= 0, 1'b1);
        fs_at = -1;
        for (int i = 0; i < FRAME_GAP + 10 && fs_at < 0; i++) begin
            tick();
            if (f_sync) fs_at = n;
        end
        checkOutput("gap_len", fs_at - done_at, FRAME_GAP);
        checkOutput("cont_relatch", {Mode, constVal, X, Y}, {3'b011, 12'h222, 2'd2, 2'd3});
        for (int i = 0; i < 5; i++) tick();
        continuous = 1'b0;
        done_at = -1;
        for (int i = 0; i < LINES * LEN_LINE + 50 && done_at < 0; i++) begin
            tick();
            if (frame_done) done_at = n;
        end
        checkOutput("cont_drop_completes", done_at - fs_at, 1 + LINES * LEN_LINE);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (f_sync || busy) cnt++;
        end
        checkOutput("cont_drop_idle", cnt, 32'd0);

        // en dropped during the last line: no frame_done
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 12'h321, 2'd1, 2'd0);
        tick();
        frame_req = 1'b0;
        got = -1;
        for (int i = 0; i < LINES * LEN_LINE + 20 && got < 0; i++) begin
            tick();
            if (sync && line_idx == 5'(LINES - 1)) got = n;
        end
        checkOutput("reach_line10", got >= 0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0;
        tick();
        checkOutput("abort_outputs", {f_sync, sync, busy, frame_done}, 4'd0);
        en = 1'b1;
        cnt = 0;
        for (int i = 0; i < LEN_LINE + 100; i++) begin
            tick();
            if (sync || frame_done || busy) cnt++;
        end
        checkOutput("abort_quiet", cnt, 32'd0);

        // en and frame_req rising together
        en = 1'b0;
        tick();
        en = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        checkOutput("en_req_same", {f_sync, sync, busy}, 3'b111);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();

        // Randomised traffic, checked cycle by cycle against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 399) == 0) en = ~en;
            if ($urandom_range(0, 1999) == 0) continuous = ~continuous;
            frame_req = ($urandom_range(0, 59) == 0);
            cfg_mode  = 3'($urandom);
            cfg_const = 12'($urandom);
            cfg_x     = 2'($urandom);
            cfg_y     = 2'($urandom);
            if ($urandom_range(0, 2999) == 0) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
